// File: rtl/membus_if.sv
// Video memory bus: CPU register-bus port, renderer fetch ports and memory side.
interface membus_if #(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = 18
);
  // CPU register-bus port
  logic                     cpu_strobe;
  logic                     cpu_write;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [7:0]               cpu_wrdata;
  logic                     cpu_ack;
  logic [7:0]               cpu_rddata;
  // renderer read-only fetch ports
  logic [NUM_RD-1:0]        rd_strobe;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_ack;
  // memory side
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_strobe;
  logic                     mem_write;
  logic [31:0]              mem_wrdata;
  logic [3:0]               mem_bytesel;
  logic [31:0]              mem_rddata;

  // arbiter side
  modport slave (
    input  cpu_strobe, cpu_write, cpu_addr, cpu_wrdata,
    output cpu_ack, cpu_rddata,
    input  rd_strobe, rd_addr,
    output rd_ack,
    output mem_addr, mem_strobe, mem_write, mem_wrdata, mem_bytesel,
    input  mem_rddata
  );

  // bus masters and memories
  modport master (
    output cpu_strobe, cpu_write, cpu_addr, cpu_wrdata,
    input  cpu_ack, cpu_rddata,
    output rd_strobe, rd_addr,
    input  rd_ack,
    input  mem_addr, mem_strobe, mem_write, mem_wrdata, mem_bytesel,
    output mem_rddata
  );
endinterface

// File: rtl/membus_arbiter.sv
// Video memory bus arbiter: CPU has absolute priority, renderer ports share
// the remaining cycles round-robin. Grant is combinational, acks registered.
// A CPU strobe always wins arbitration in its own cycle, so back-to-back
// strobes are served on consecutive cycles and no CPU request is left waiting.
module membus_arbiter #(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = 18
) (
  input  logic     clk,
  input  logic     rst,
  membus_if.slave  bus
);
  localparam int unsigned PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_RD-1:0] rd_ack_q;
  logic              cpu_ack_q;
  logic              cpu_rd_q;
  logic [1:0]        cpu_sel_q;
  logic [7:0]        rddata_q;

  logic              cpu_gnt;
  logic [NUM_RD-1:0] elig;
  logic [NUM_RD-1:0] rd_gnt;
  logic              rd_any;
  logic [PTR_W-1:0]  rd_idx;
  logic [PTR_W-1:0]  cand;
  logic [7:0]        sel_byte;

  assign cpu_gnt = bus.cpu_strobe;
  // a port whose ack is visible this cycle must not be granted again
  assign elig    = bus.rd_strobe & ~rd_ack_q;

  // round-robin pick of the first eligible renderer port after rr_ptr
  always_comb begin
    rd_gnt = '0;
    rd_any = 1'b0;
    rd_idx = '0;
    cand   = '0;
    if (!cpu_gnt) begin
      for (int unsigned k = 1; k <= NUM_RD; k++) begin
        cand = PTR_W'((32'(rr_ptr) + k) % NUM_RD);
        if (!rd_any && elig[cand]) begin
          rd_any = 1'b1;
          rd_idx = cand;
        end
      end
    end
    if (rd_any) rd_gnt[rd_idx] = 1'b1;
  end

  // memory-side outputs driven from the current grant
  always_comb begin
    bus.mem_strobe  = cpu_gnt | rd_any;
    bus.mem_addr    = '0;
    bus.mem_write   = 1'b0;
    bus.mem_bytesel = 4'b0000;
    bus.mem_wrdata  = {4{bus.cpu_wrdata}};
    if (cpu_gnt) begin
      bus.mem_addr    = bus.cpu_addr;
      bus.mem_write   = bus.cpu_write;
      bus.mem_bytesel = bus.cpu_write ? (4'b0001 << bus.cpu_addr[1:0]) : 4'b1111;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (rd_gnt[i]) begin
          bus.mem_addr    = bus.rd_addr[i*ADDR_W +: ADDR_W];
          bus.mem_bytesel = 4'b1111;
        end
      end
    end
  end

  // byte lane of the returning word addressed by the CPU read
  always_comb begin
    case (cpu_sel_q)
      2'd0:    sel_byte = bus.mem_rddata[7:0];
      2'd1:    sel_byte = bus.mem_rddata[15:8];
      2'd2:    sel_byte = bus.mem_rddata[23:16];
      default: sel_byte = bus.mem_rddata[31:24];
    endcase
  end

  // ack pipeline, round-robin pointer and CPU read-data holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= PTR_W'(NUM_RD - 1);
      rd_ack_q  <= '0;
      cpu_ack_q <= 1'b0;
      cpu_rd_q  <= 1'b0;
      cpu_sel_q <= 2'd0;
      rddata_q  <= 8'h00;
    end else begin
      rd_ack_q  <= rd_gnt;
      cpu_ack_q <= cpu_gnt;
      cpu_rd_q  <= cpu_gnt & ~bus.cpu_write;
      cpu_sel_q <= bus.cpu_addr[1:0];
      if (rd_any)   rr_ptr   <= rd_idx;
      if (cpu_rd_q) rddata_q <= sel_byte;
    end
  end

  assign bus.rd_ack     = rd_ack_q;
  assign bus.cpu_ack    = cpu_ack_q;
  // read byte is presented in the ack cycle, then held until the next read ack
  assign bus.cpu_rddata = cpu_rd_q ? sel_byte : rddata_q;

endmodule
